// File: rtl/ema_update_ctrl.sv
// Sequential EMA update controller: y <= y + alpha*(x - y), using an external
// shift-add multiplier driven through a start/finish handshake.
module ema_update_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic signed [WIDTH-1:0] sample_in,
    input  logic        [WIDTH-1:0] alpha,
    output logic                    ema_valid,
    output logic signed [WIDTH-1:0] ema_out,
    output logic                    primed,
    output logic                    ema_multshiftadd_start,
    output logic signed [WIDTH-1:0] ema_multshiftadd_multiplicand,
    output logic        [WIDTH-1:0] ema_multshiftadd_multiplier,
    input  logic                    multshiftadd_ema_finish,
    input  logic signed [WIDTH-1:0] multshiftadd_ema_product
);

    // state | meaning
    // IDLE  | ready for a sample; applies pending clear
    // SUB   | saturated x - y into the multiplicand register
    // REQ   | one-cycle multiply start
    // WAIT  | hold operands until the multiplier finishes
    // ACC   | y <= sat(y + product)
    // OUT   | one-cycle ema_valid
    typedef enum logic [2:0] {IDLE, SUB, REQ, WAIT, ACC, OUT} state_t;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] x_r;
    logic signed [WIDTH-1:0] diff_r;
    logic signed [WIDTH-1:0] prod_r;
    logic        [WIDTH-1:0] alpha_r;
    logic                    primed_r;
    logic                    clear_pend;

    logic                    accept;
    logic                    clr_now;
    logic                    eff_primed;
    logic        [WIDTH:0]   diff_ext;
    logic        [WIDTH:0]   sum_ext;

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Overflow out of WIDTH bits shows up as the two top bits disagreeing.
    function automatic logic [WIDTH-1:0] sat(input logic [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1])
            return v[WIDTH] ? SAT_MIN : SAT_MAX;
        else
            return v[WIDTH-1:0];
    endfunction

    assign accept     = sample_valid && (state == IDLE);
    assign clr_now    = clear || clear_pend;
    assign eff_primed = primed_r && !clr_now;
    assign diff_ext   = {x_r[WIDTH-1], x_r} - {y[WIDTH-1], y};
    assign sum_ext    = {y[WIDTH-1], y} + {prod_r[WIDTH-1], prod_r};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = eff_primed ? SUB : OUT;
            SUB:  state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: if (multshiftadd_ema_finish) state_nxt = ACC;
            ACC:  state_nxt = OUT;
            OUT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            y          <= '0;
            x_r        <= '0;
            diff_r     <= '0;
            prod_r     <= '0;
            alpha_r    <= '0;
            primed_r   <= 1'b0;
            clear_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (clr_now) begin
                        primed_r   <= 1'b0;
                        clear_pend <= 1'b0;
                    end
                    if (accept) begin
                        if (!eff_primed) begin
                            y        <= sample_in;
                            primed_r <= 1'b1;
                        end else begin
                            x_r     <= sample_in;
                            alpha_r <= alpha;
                        end
                    end
                end
                SUB:  diff_r <= sat(diff_ext);
                WAIT: if (multshiftadd_ema_finish) prod_r <= multshiftadd_ema_product;
                ACC:  y <= sat(sum_ext);
                default: ;
            endcase
            // A clear seen mid-update is deferred so the update still completes.
            if (state != IDLE && clear)
                clear_pend <= 1'b1;
        end
    end

    assign sample_ready                  = (state == IDLE);
    assign ema_valid                     = (state == OUT);
    assign ema_multshiftadd_start        = (state == REQ);
    assign ema_multshiftadd_multiplicand = diff_r;
    assign ema_multshiftadd_multiplier   = alpha_r;
    assign ema_out                       = y;
    assign primed                        = primed_r;

endmodule

// File: tb/tb_ema_update_ctrl.sv
// Directed bench for ema_update_ctrl; the multiplier is a hand-driven stub
// returning precomputed floor products.
module tb_ema_update_ctrl;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clear = 1'b0;
    logic               sample_valid = 1'b0;
    logic               sample_ready;
    logic signed [15:0] sample_in = '0;
    logic        [15:0] alpha = '0;
    logic               ema_valid;
    logic signed [15:0] ema_out;
    logic               primed;
    logic               mstart;
    logic signed [15:0] mcand;
    logic        [15:0] mult;
    logic               finish = 1'b0;
    logic signed [15:0] product = '0;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;
    int exp_starts = 0;

    ema_update_ctrl #(.WIDTH(16)) dut (
        .clk                           (clk),
        .rst_n                         (rst_n),
        .clear                         (clear),
        .sample_valid                  (sample_valid),
        .sample_ready                  (sample_ready),
        .sample_in                     (sample_in),
        .alpha                         (alpha),
        .ema_valid                     (ema_valid),
        .ema_out                       (ema_out),
        .primed                        (primed),
        .ema_multshiftadd_start        (mstart),
        .ema_multshiftadd_multiplicand (mcand),
        .ema_multshiftadd_multiplier   (mult),
        .multshiftadd_ema_finish       (finish),
        .multshiftadd_ema_product      (product)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rst_n && mstart) start_cnt++;

    typedef struct {
        int x;
        int a;
        bit clr;
        bit pp;
        int m;
        int mc;
        int prod;
        int exp_out;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!sample_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", int'(sample_ready), 1);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        wait_ready();
        sample_valid = 1'b1;
        sample_in    = 16'(v.x);
        alpha        = 16'(v.a);
        clear        = v.clr;
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        if (!v.pp) begin
            chk($sformatf("v%0d_valid_unprimed", idx), int'(ema_valid), 1);
            chk($sformatf("v%0d_out", idx), int'(ema_out), v.exp_out);
            chk($sformatf("v%0d_primed", idx), int'(primed), 1);
        end else begin
            exp_starts++;
            chk($sformatf("v%0d_sub_start", idx), int'(mstart) + int'(ema_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_req_start", idx), int'(mstart), 1);
            chk($sformatf("v%0d_mcand", idx), int'(mcand), v.mc);
            chk($sformatf("v%0d_mult", idx), int'(mult), v.a);
            for (int k = 1; k <= v.m; k++) begin
                @(negedge clk);
                chk($sformatf("v%0d_wait_hold", idx),
                    ((int'(mstart) == 0) && (int'(mcand) == v.mc) && (int'(mult) == v.a)
                     && !ema_valid && !sample_ready) ? 1 : 0, 1);
                if (k == v.m) begin
                    finish  = 1'b1;
                    product = 16'(v.prod);
                end
            end
            @(negedge clk);
            finish  = 1'b0;
            product = '0;
            chk($sformatf("v%0d_acc_novalid", idx), int'(ema_valid), 0);
            @(negedge clk);
            chk($sformatf("v%0d_valid", idx), int'(ema_valid), 1);
            chk($sformatf("v%0d_out", idx), int'(ema_out), v.exp_out);
        end
        @(negedge clk);
        chk($sformatf("v%0d_idle", idx), int'(ema_valid) * 2 + int'(sample_ready), 1);
        chk($sformatf("v%0d_starts", idx), start_cnt, exp_starts);
    endtask

    initial begin
        //          x       alpha   clr pp  M  mcand   prod    y
        vecs[0] = '{  1000, 'h4000, 0, 0, 0,      0,      0,   1000};
        vecs[1] = '{  2000, 'h4000, 0, 1, 5,   1000,    250,   1250};
        vecs[2] = '{     0, 'h4000, 0, 1, 2,  -1250,   -313,    937};
        vecs[3] = '{ 32000, 'h4000, 1, 0, 0,      0,      0,  32000};
        vecs[4] = '{-32768, 'hFFFF, 0, 1, 1, -32768, -32768,   -768};
        vecs[5] = '{-32768, 'hFFFF, 1, 0, 0,      0,      0, -32768};
        vecs[6] = '{ 32767, 'hFFFF, 0, 1, 3,  32767,  32766,     -2};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out", int'(ema_out), 0);
        chk("rst_primed", int'(primed), 0);
        chk("rst_valid_start", int'(ema_valid) + int'(mstart), 0);
        chk("rst_ready", int'(sample_ready), 1);
        chk("rst_operands", int'(mcand) + int'(mult), 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Busy: sample_valid held and clear pulsed while waiting on the multiplier.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 16'sd98;
        alpha        = 16'h8000;
        @(negedge clk);
        sample_in = 16'sd7777;
        exp_starts++;
        repeat (3) @(negedge clk);
        chk("busy_ready", int'(sample_ready), 0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_hold_mcand", int'(mcand), 100);
        finish  = 1'b1;
        product = 16'sd50;
        @(negedge clk);
        finish  = 1'b0;
        product = '0;
        @(negedge clk);
        sample_valid = 1'b0;
        chk("busy_valid", int'(ema_valid), 1);
        chk("busy_out", int'(ema_out), 48);
        chk("busy_primed_kept", int'(primed), 1);
        chk("busy_one_start", start_cnt, exp_starts);
        @(negedge clk);
        chk("busy_idle_primed", int'(primed), 1);
        @(negedge clk);
        chk("busy_cleared", int'(primed), 0);
        run_vec('{500, 'h8000, 0, 0, 0, 0, 0, 500}, 7);

        // Reset in WAIT, then a stray finish.
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = 16'sd100;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_wait", int'(sample_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", int'(ema_out), 0);
        chk("mid_rst_primed", int'(primed), 0);
        chk("mid_rst_ctl", int'(ema_valid) + int'(mstart), 0);
        chk("mid_rst_operands", int'(mcand) + int'(mult), 0);
        @(negedge clk);
        rst_n = 1'b1;
        finish  = 1'b1;
        product = 16'sd1234;
        @(negedge clk);
        finish  = 1'b0;
        product = '0;
        for (int k = 0; k < 4; k++) begin
            chk("late_finish_ignored",
                (int'(ema_valid) == 0 && int'(ema_out) == 0 && sample_ready) ? 1 : 0, 1);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ema_update_ctrl.md
Name: ema_update_ctrl

Overview:
- Sequential controller for the synchronization EMA filter. It computes y <= y + alpha*(x - y), one accepted sample at a time.
- Sits directly upstream and downstream of the shift-add multiplier:
  - drives the multiplier's start, multiplicand and multiplier inputs;
  - consumes its finish pulse and truncated product.
- Holds the EMA state register and presents the updated estimate to the timing-recovery logic.

Parameters:
- WIDTH, 16: width of samples, EMA state, alpha and product. Signed two's complement, except alpha, which is an unsigned fraction of 2^WIDTH.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous request to un-prime the filter.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  high only in IDLE; a sample is accepted when sample_valid && sample_ready.
- sample_in  input  WIDTH  signed new sample x.
- alpha  input  WIDTH  unsigned smoothing factor; value = alpha/2^WIDTH. Sampled at acceptance.
- ema_valid  output  1  one-cycle pulse; ema_out has been updated.
- ema_out  output  WIDTH  signed EMA state y, continuously driven from the state register.
- primed  output  1  high once the first sample has been loaded.
- ema_multshiftadd_start  output  1  one-cycle multiply request.
- ema_multshiftadd_multiplicand  output  WIDTH  signed saturated difference.
- ema_multshiftadd_multiplier  output  WIDTH  latched alpha.
- multshiftadd_ema_finish  input  1  one-cycle pulse; the product is valid in this cycle only.
- multshiftadd_ema_product  input  WIDTH  signed floor(multiplicand*multiplier / 2^WIDTH).

Behaviour:
- Clock and reset: clk is the single clock. rst_n is asynchronous, active-low.
- Reset values:
  - state IDLE; y = 0; primed = 0; clear_pend = 0;
  - ema_valid = 0; ema_multshiftadd_start = 0;
  - diff, alpha and product registers = 0;
  - sample_ready = 1 from the first cycle after reset.
- Reset mid-operation: abandons any transaction. Any finish arriving later is ignored, because finish is examined only in WAIT.
- IDLE:
  - sample_ready = 1.
  - If clear (or clear_pend): primed <= 0, clear_pend <= 0. Any sample offered that cycle is still accepted, using the post-clear (unprimed) path.
  - On accept with primed = 0: y <= sample_in, primed <= 1, go to OUT.
  - On accept with primed = 1: latch x and alpha, go to SUB.
- SUB:
  - Compute d = x - y in WIDTH+1 bits.
  - Saturate d to WIDTH bits: max 2^(WIDTH-1)-1, min -2^(WIDTH-1).
  - Register the result as the multiplicand. Go to REQ.
- REQ: ema_multshiftadd_start = 1 for exactly this cycle; multiplicand and multiplier are stable. Go to WAIT.
- WAIT:
  - start = 0; multiplicand and multiplier are held stable.
  - Stay until multshiftadd_ema_finish = 1. In that cycle capture the product and go to ACC.
  - No timeout; the multiplier latency is variable.
- ACC:
  - y <= y + product, computed in WIDTH+1 bits and saturated to WIDTH. Mathematically saturation never triggers; it is kept as a guard.
  - Go to OUT.
- OUT: ema_valid = 1 for one cycle with the updated ema_out. Go to IDLE.
- Latency:
  - Primed path: accept at cycle 0 (IDLE), SUB at 1, start at 2, finish at 2+M, ACC at 3+M, ema_valid at 4+M, where M >= 1 is the multiplier latency from start.
  - Unprimed path: ema_valid at cycle 1.
- clear while not IDLE: latched into clear_pend. The current update completes normally, including its ema_valid. Priming is cleared on the next IDLE cycle.
- sample_valid while busy: ignored (sample_ready = 0). No buffering.
- primed and y: primed stays high until clear or reset. y holds between updates.
- Outputs: all outputs are registered or decoded from the registered state; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then WIDTH = 16 and alpha = 0x4000. Send x = 1000 -> ema_valid 1 cycle after accept, ema_out = 1000, primed = 1, no start pulse.
- Then x = 2000 -> multiplicand = 1000 and multiplier = 0x4000 held through WAIT; product stub 250 after M = 5 -> ema_out = 1250, ema_valid at accept+9.
- Then x = 0 (negative path) -> multiplicand = -1250; stub returns -313 (floor) -> ema_out = 937.
- Saturation, alpha = 0xFFFF:
  - y = 32000, x = -32768 -> multiplicand = -32768; product -32768 -> ema_out = -768.
  - y = -32768, x = 32767 -> multiplicand = 32767; product 32766 -> ema_out = -2.
- Control during busy:
  - sample_valid held high during WAIT -> sample_ready = 0, no second start.
  - clear pulsed in WAIT -> update completes with ema_valid, then primed = 0 the cycle after returning to IDLE; next x = 500 -> ema_out = 500 with no multiply.
- Reset asserted in WAIT -> all outputs return to reset values immediately. A late finish pulse is ignored; ema_valid stays 0.
